// File: rtl/keypad_row_decoder.sv
// keypad_row_decoder
//   Decodes the active-low rows of a 4x4 keypad scanned column by column.
//   One sample is taken per column dwell (on cnt_end); a full sweep ends
//   at column 3 and yields NONE, SINGLE(code) or MULTI. Sweep results are
//   debounced over DEBOUNCE_SCANS consecutive sweeps for both press and
//   release, and a pressed key locks out rollover until it is released.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   cnt_end    one-cycle strobe on the last cycle of a column dwell
//   col_drive  active-low one-cold column drive from the scan driver
//   row_in     raw active-low rows, asynchronous to clk
//   key_code   accepted key, row*4 + col
//   key_valid  one-cycle pulse when a new key is accepted
//   key_held   high while the accepted key is considered pressed
//   multi_key  high when the last sweep saw two or more pressed keys
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no key accepted, waiting for a sweep with a single key
// DEBOUNCE | counting consecutive sweeps that show the same single key
// PRESSED  | key accepted; further keys are ignored (rollover lockout)
// RELEASE  | counting consecutive empty sweeps before dropping key_held

module keypad_row_decoder #(
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_end,
  input  logic [3:0] col_drive,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } result_t;

  // Registers
  logic [3:0] rows_meta_q, rows_meta_d;
  logic [3:0] rows_s_q,    rows_s_d;
  logic [1:0] acc_hits_q,  acc_hits_d;
  logic [3:0] acc_code_q,  acc_code_d;
  state_t     state_q,     state_d;
  logic [3:0] cand_q,      cand_d;
  logic [3:0] deb_q,       deb_d;
  logic [3:0] rel_q,       rel_d;
  logic [3:0] key_code_q,  key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q,  key_held_d;
  logic       multi_key_q, multi_key_d;

  // Sample decode
  logic       col_valid;
  logic [1:0] col_idx;
  logic [3:0] row_low;
  logic [2:0] sample_hits;
  logic [1:0] first_row;
  logic [3:0] sample_code;
  logic       sample_ok;
  logic       sweep_end;
  logic [2:0] sum_hits;
  logic [1:0] sat_hits;
  logic [3:0] sweep_code;
  result_t    res_kind;
  logic [3:0] deb_inc;
  logic [3:0] rel_inc;

  always_comb begin
    col_valid = 1'b1;
    col_idx   = 2'd0;
    case (col_drive)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_valid = 1'b0;
    endcase
  end

  always_comb begin
    row_low     = ~rows_s_q;
    sample_hits = {2'b00, row_low[0]} + {2'b00, row_low[1]}
                + {2'b00, row_low[2]} + {2'b00, row_low[3]};
    if (row_low[0])      first_row = 2'd0;
    else if (row_low[1]) first_row = 2'd1;
    else if (row_low[2]) first_row = 2'd2;
    else                 first_row = 2'd3;
    sample_code = {first_row, col_idx};
    sample_ok   = cnt_end & col_valid;
    sweep_end   = sample_ok & (col_idx == 2'd3);
  end

  // The column-3 sample contributes to the result it terminates, so the
  // result is built from the accumulator plus the current sample.
  always_comb begin
    sum_hits   = {1'b0, acc_hits_q} + sample_hits;
    sat_hits   = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
    sweep_code = (acc_hits_q == 2'd0) ? sample_code : acc_code_q;
    case (sat_hits)
      2'd0:    res_kind = RES_NONE;
      2'd1:    res_kind = RES_SINGLE;
      default: res_kind = RES_MULTI;
    endcase
  end

  always_comb begin
    rows_meta_d = row_in;
    rows_s_d    = rows_meta_q;
    acc_hits_d  = acc_hits_q;
    acc_code_d  = acc_code_q;
    if (sample_ok) begin
      if (sweep_end) begin
        acc_hits_d = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_hits_d = sat_hits;
        if ((acc_hits_q == 2'd0) && (sample_hits != 3'd0)) begin
          acc_code_d = sample_code;
        end
      end
    end
  end

  always_comb begin
    deb_inc     = deb_q + 4'd1;
    rel_inc     = rel_q + 4'd1;
    state_d     = state_q;
    cand_d      = cand_q;
    deb_d       = deb_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;

    if (sweep_end) begin
      multi_key_d = (res_kind == RES_MULTI);
      case (state_q)
        IDLE: begin
          if (res_kind == RES_SINGLE) begin
            state_d = DEBOUNCE;
            cand_d  = sweep_code;
            deb_d   = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (res_kind == RES_SINGLE) begin
            if (sweep_code == cand_q) begin
              if (deb_inc == DEB_LAST) begin
                state_d     = PRESSED;
                deb_d       = 4'd0;
                key_code_d  = cand_q;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
              end else begin
                deb_d = deb_inc;
              end
            end else begin
              cand_d = sweep_code;
              deb_d  = 4'd1;
            end
          end else begin
            state_d = IDLE;
            deb_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (res_kind == RES_NONE) begin
            state_d = RELEASE;
            rel_d   = 4'd1;
          end
        end
        RELEASE: begin
          if (res_kind == RES_NONE) begin
            if (rel_inc == DEB_LAST) begin
              state_d    = IDLE;
              rel_d      = 4'd0;
              key_held_d = 1'b0;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            // Key came back before the release was confirmed: treat as
            // the same press, no new key_valid.
            state_d = PRESSED;
            rel_d   = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta_q <= 4'b1111;
      rows_s_q    <= 4'b1111;
      acc_hits_q  <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      deb_q       <= 4'd0;
      rel_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      rows_meta_q <= rows_meta_d;
      rows_s_q    <= rows_s_d;
      acc_hits_q  <= acc_hits_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Testbench for keypad_row_decoder: directed sweep table, invalid column
// patterns, asynchronous reset sequences and randomized sweeps compared
// against a sweep-history reference model.

module tb_keypad_row_decoder;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_end;
  logic [3:0] col_drive;
  logic [3:0] row_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  always #5 clk = ~clk;

  keypad_row_decoder #(.DEBOUNCE_SCANS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_end   (cnt_end),
    .col_drive (col_drive),
    .row_in    (row_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of keys seen in the current sweep, and the
  // history of sweep results (-1 none, -2 multi, else the key code).
  int sweep_keys[$];
  int hist[$];
  int m_code, m_held, m_multi, m_valid;

  task automatic model_reset();
    sweep_keys.delete();
    hist.delete();
    m_code = 0; m_held = 0; m_multi = 0; m_valid = 0;
  endtask

  // Common value of the last N sweep results, or -99 if they differ.
  function automatic int run_value();
    int base;
    if (hist.size() < N) return -99;
    base = hist.size() - N;
    for (int i = base + 1; i < hist.size(); i++)
      if (hist[i] != hist[base]) return -99;
    return hist[base];
  endfunction

  task automatic model_sweep_end();
    int res, rv;
    if (sweep_keys.size() == 0)      res = -1;
    else if (sweep_keys.size() == 1) res = sweep_keys[0];
    else                             res = -2;
    sweep_keys.delete();
    m_multi = (res == -2) ? 1 : 0;
    hist.push_back(res);
    if (hist.size() > 16) void'(hist.pop_front());
    rv = run_value();
    if (m_held == 0 && rv >= 0) begin
      m_held = 1; m_valid = 1; m_code = rv;
    end else if (m_held == 1 && rv == -1) begin
      m_held = 0;
    end
  endtask

  function automatic int col_of(input logic [3:0] cd);
    case (cd)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] p;
    p = 4'b1111;
    p[c] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] rows_for(input logic [15:0] mask, input int c);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = ~mask[k*4 + c];
    return r;
  endfunction

  // One column dwell of 8 cycles, cnt_end on the last one. key_valid must
  // be low on every non-sample cycle; after the sample the outputs are
  // optionally compared with the model.
  task automatic dwell(input logic [3:0] cd, input logic [3:0] rows, input bit use_model);
    int c;
    col_drive = cd;
    row_in    = rows;
    for (int i = 0; i < 8; i++) begin
      cnt_end = (i == 7);
      @(posedge clk); #1;
      if (i < 7) chk("valid_idle", int'(key_valid), 0);
    end
    cnt_end = 1'b0;
    m_valid = 0;
    c = col_of(cd);
    if (c >= 0) begin
      for (int r = 0; r < 4; r++)
        if (!rows[r]) sweep_keys.push_back(r*4 + c);
      if (c == 3) model_sweep_end();
    end
    if (use_model) begin
      chk("mdl_valid", int'(key_valid), m_valid);
      chk("mdl_code",  int'(key_code),  m_code);
      chk("mdl_held",  int'(key_held),  m_held);
      chk("mdl_multi", int'(multi_key), m_multi);
    end
  endtask

  task automatic sweep(input logic [15:0] mask, input bit use_model);
    for (int c = 0; c < 4; c++) dwell(col_pat(c), rows_for(mask, c), use_model);
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code",  int'(key_code),  0);
    chk("rst_held",  int'(key_held),  0);
    chk("rst_multi", int'(multi_key), 0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] mask;
    int          v;
    int          code;
    int          held;
    int          multi;
  } vec_t;

  vec_t tbl[30];

  initial begin
    logic [15:0] mask;
    logic [3:0]  bad_cols[5];
    int kind, reps, k1, k2;

    tbl[0]  = '{16'h0000, 0, 0, 0, 0};
    tbl[1]  = '{16'h0000, 0, 0, 0, 0};
    tbl[2]  = '{16'h0200, 0, 0, 0, 0};
    tbl[3]  = '{16'h0200, 0, 0, 0, 0};
    tbl[4]  = '{16'h0000, 0, 0, 0, 0};
    tbl[5]  = '{16'h0200, 0, 0, 0, 0};
    tbl[6]  = '{16'h0200, 0, 0, 0, 0};
    tbl[7]  = '{16'h0200, 1, 9, 1, 0};
    tbl[8]  = '{16'h0200, 0, 9, 1, 0};
    tbl[9]  = '{16'h0000, 0, 9, 1, 0};
    tbl[10] = '{16'h0000, 0, 9, 1, 0};
    tbl[11] = '{16'h0000, 0, 9, 0, 0};
    tbl[12] = '{16'h4001, 0, 9, 0, 1};
    tbl[13] = '{16'h0001, 0, 9, 0, 0};
    tbl[14] = '{16'h0001, 0, 9, 0, 0};
    tbl[15] = '{16'h0001, 1, 0, 1, 0};
    tbl[16] = '{16'h4001, 0, 0, 1, 1};
    tbl[17] = '{16'h4001, 0, 0, 1, 1};
    tbl[18] = '{16'h0000, 0, 0, 1, 0};
    tbl[19] = '{16'h0200, 0, 0, 1, 0};
    tbl[20] = '{16'h0000, 0, 0, 1, 0};
    tbl[21] = '{16'h0000, 0, 0, 1, 0};
    tbl[22] = '{16'h0000, 0, 0, 0, 0};
    tbl[23] = '{16'h0020, 0, 0, 0, 0};
    tbl[24] = '{16'h0040, 0, 0, 0, 0};
    tbl[25] = '{16'h0040, 0, 0, 0, 0};
    tbl[26] = '{16'h0040, 1, 6, 1, 0};
    tbl[27] = '{16'h0000, 0, 6, 1, 0};
    tbl[28] = '{16'h0000, 0, 6, 1, 0};
    tbl[29] = '{16'h0000, 0, 6, 0, 0};

    bad_cols[0] = 4'b1111; bad_cols[1] = 4'b1100; bad_cols[2] = 4'b0000;
    bad_cols[3] = 4'b1010; bad_cols[4] = 4'b0011;

    rst = 1'b1; cnt_end = 1'b0; col_drive = 4'b1111; row_in = 4'b1111;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(key_valid), 0);
    chk("reset_code",  int'(key_code),  0);
    chk("reset_held",  int'(key_held),  0);
    chk("reset_multi", int'(multi_key), 0);
    rst = 1'b0;

    // Directed sweeps: press/release, bounce, multi-key, rollover lockout.
    for (int i = 0; i < 30; i++) begin
      sweep(tbl[i].mask, 1'b0);
      chk("tbl_valid", int'(key_valid), tbl[i].v);
      chk("tbl_code",  int'(key_code),  tbl[i].code);
      chk("tbl_held",  int'(key_held),  tbl[i].held);
      chk("tbl_multi", int'(multi_key), tbl[i].multi);
    end

    // Non one-cold column drive: samples ignored even with all rows low.
    for (int i = 0; i < 4; i++) dwell(4'b1111, 4'b0000, 1'b1);
    dwell(4'b1100, 4'b0000, 1'b1);
    chk("inv_multi", int'(multi_key), 0);
    chk("inv_held",  int'(key_held),  0);
    // Ignored dwell inside a sweep must not disturb the accumulation.
    dwell(4'b1110, 4'b1110, 1'b1);
    dwell(4'b1111, 4'b0000, 1'b1);
    dwell(4'b1101, 4'b1111, 1'b1);
    dwell(4'b1011, 4'b1111, 1'b1);
    dwell(4'b0111, 4'b1111, 1'b1);
    chk("inv_sweep_multi", int'(multi_key), 0);

    // Reset in DEBOUNCE, then a partial first sweep (columns 2,3 only).
    sweep(16'h0200, 1'b1);
    sweep(16'h0200, 1'b1);
    dwell(4'b1110, rows_for(16'h0200, 0), 1'b1);
    dwell(4'b1101, rows_for(16'h0200, 1), 1'b1);
    reset_mid();
    dwell(4'b1011, rows_for(16'h8000, 2), 1'b1);
    dwell(4'b0111, rows_for(16'h8000, 3), 1'b1);
    chk("partial_valid", int'(key_valid), 0);
    sweep(16'h8000, 1'b1);
    chk("after_rst_not_yet", int'(key_valid), 0);
    sweep(16'h8000, 1'b1);
    chk("after_rst_valid", int'(key_valid), 1);
    chk("after_rst_code",  int'(key_code),  15);

    // Reset in PRESSED, then a fresh key needs N full sweeps.
    sweep(16'h8000, 1'b1);
    dwell(4'b1110, 4'b1111, 1'b1);
    reset_mid();
    for (int c = 1; c < 4; c++) dwell(col_pat(c), 4'b1111, 1'b1);
    sweep(16'h0000, 1'b1);
    sweep(16'h0200, 1'b1);
    sweep(16'h0200, 1'b1);
    chk("p2_not_yet", int'(key_valid), 0);
    sweep(16'h0200, 1'b1);
    chk("p2_valid", int'(key_valid), 1);
    chk("p2_code",  int'(key_code),  9);

    // Randomized sweeps against the model.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      k1 = $urandom_range(0, 15);
      k2 = (k1 + $urandom_range(1, 15)) % 16;
      mask = 16'h0000;
      if (kind >= 4) mask[k1] = 1'b1;
      if (kind >= 8) mask[k2] = 1'b1;
      reps = $urandom_range(1, 4);
      for (int r = 0; r < reps; r++) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 7) == 0)
            dwell(bad_cols[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), 1'b1);
          dwell(col_pat(c), rows_for(mask, c), 1'b1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
